// File: rtl/mem_stage_access_ctrl_pkg.sv
// Shared types and defaults for the memory-stage access controller.
// The optional transaction timeout is enabled with the MEM_TIMEOUT_EN macro.

package mem_stage_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   localparam int DEFAULT_N       = 24;
   localparam int DEFAULT_TIMEOUT = 255;

   // Timeout counter width: wide enough for the terminal count, never below 8 bits
   function automatic int timeout_cnt_width(input int timeout);
      int w;
      w = $clog2(timeout);
      return (w < 8) ? 8 : w;
   endfunction

endpackage

// File: rtl/mem_stage_access_ctrl_timeout_counter.sv
// Wait-cycle counter for a memory transaction in flight.
// Used by mem_stage_access_ctrl only when MEM_TIMEOUT_EN is defined.
// The terminal output goes high while the count equals TERMINAL.

module mem_timeout_counter #(
   parameter int WIDTH    = 8,
   parameter int TERMINAL = 254
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam logic [WIDTH-1:0] TC = WIDTH'(TERMINAL);

   logic [WIDTH-1:0] count;

   // Clear takes priority so every new transaction starts counting from zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   assign terminal = (count == TC);

endmodule

// File: rtl/mem_stage_access_ctrl.sv
// Memory-stage access controller: turns a load/store in the M stage into a
// req/ack transaction on a variable-latency data memory. It stalls the
// pipeline until the access completes and hands load data to MEM/WB.
// Optional feature: define MEM_TIMEOUT_EN to abort transactions that see no
// ack within TIMEOUT busy cycles. MemErrM then flags the abort until reset.

module mem_stage_access_ctrl
   import mem_stage_pkg::*;
#(
   parameter int N       = DEFAULT_N,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         MemtoRegM,
   input  logic         MemWriteM,
   input  logic [N-1:0] ALUResultM,
   input  logic [N-1:0] WriteDataM,
   output logic         StallM,
   output logic [N-1:0] ReadDataM,
   output logic         ReadValidM,
   output logic         MemErrM,
   output logic         mem_req,
   output logic         mem_we,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   input  logic         mem_ack,
   input  logic [N-1:0] mem_rdata
);

   // A zero timeout would leave no busy cycle to wait in
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("mem_stage_access_ctrl: TIMEOUT must be at least 1");
   end

   mem_state_t state;
   mem_state_t next_state;

   logic access;
   logic timeout_hit;

   // A store takes precedence when both control bits are set
   assign access = MemtoRegM | MemWriteM;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = timeout_cnt_width(TIMEOUT);

   logic cnt_clear;
   logic cnt_enable;
   logic cnt_terminal;

   assign cnt_clear  = (state != BUSY);
   assign cnt_enable = (state == BUSY) && !mem_ack;

   mem_timeout_counter #(
      .WIDTH    (CNT_W),
      .TERMINAL (TIMEOUT - 1)
   ) u_timeout (
      .clk      (clk),
      .rst      (rst),
      .clear    (cnt_clear),
      .enable   (cnt_enable),
      .terminal (cnt_terminal)
   );

   assign timeout_hit = (state == BUSY) && cnt_terminal && !mem_ack;

   // Sticky error flag: an abort stays visible until the next reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         MemErrM <= 1'b0;
      end else if (timeout_hit) begin
         MemErrM <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign MemErrM     = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: DONE always returns to IDLE so no access is issued twice
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (access) begin
               next_state = BUSY;
            end
         end
         BUSY: begin
            if (mem_ack || timeout_hit) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Stall output: the pipeline moves only in the single DONE cycle
   always_comb begin
      StallM = access && (state != DONE);
   end

   // Registered memory-port and load-data outputs; a cleared mem_we marks a read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         ReadDataM  <= '0;
         ReadValidM <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (access) begin
                  mem_req   <= 1'b1;
                  mem_we    <= MemWriteM;
                  mem_addr  <= ALUResultM;
                  mem_wdata <= WriteDataM;
               end else begin
                  mem_req <= 1'b0;
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (!mem_we) begin
                     ReadDataM  <= mem_rdata;
                     ReadValidM <= 1'b1;
                  end
               end else if (timeout_hit) begin
                  mem_req <= 1'b0;
                  if (!mem_we) begin
                     ReadDataM  <= '0;
                     ReadValidM <= 1'b1;
                  end
               end
            end
            DONE: begin
               ReadValidM <= 1'b0;
            end
            default: begin
               mem_req    <= 1'b0;
               ReadValidM <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Self-checking bench for mem_stage_access_ctrl.
// Table-driven accesses with a request/read-data scoreboard, plus hand-written
// reset, spurious-ack and (with MEM_TIMEOUT_EN) timeout sequences.

module tb_mem_stage_access_ctrl;

   localparam int N = 24;
   localparam int TB_TIMEOUT = 8;

   typedef struct {
      logic         load;
      logic         store;
      logic [N-1:0] addr;
      logic [N-1:0] wdata;
      logic [N-1:0] rdata;
      int           waits;
      int           expStall;
      logic         expValid;
   } vec_t;

   typedef struct {
      logic         we;
      logic [N-1:0] addr;
      logic [N-1:0] wdata;
   } req_t;

   logic         clk;
   logic         rst;
   logic         MemtoRegM;
   logic         MemWriteM;
   logic [N-1:0] ALUResultM;
   logic [N-1:0] WriteDataM;
   logic         StallM;
   logic [N-1:0] ReadDataM;
   logic         ReadValidM;
   logic         MemErrM;
   logic         mem_req;
   logic         mem_we;
   logic [N-1:0] mem_addr;
   logic [N-1:0] mem_wdata;
   logic         mem_ack;
   logic [N-1:0] mem_rdata;

   int assertCount = 0;
   int failCount   = 0;

   req_t         reqQueue[$];
   logic [N-1:0] readQueue[$];
   logic [N-1:0] lastRead;
   vec_t         vecs[5];

   mem_stage_access_ctrl #(
      .N       (N),
      .TIMEOUT (TB_TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .MemtoRegM  (MemtoRegM),
      .MemWriteM  (MemWriteM),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .StallM     (StallM),
      .ReadDataM  (ReadDataM),
      .ReadValidM (ReadValidM),
      .MemErrM    (MemErrM),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Drives one M-stage instruction from IDLE, acts as the memory, and checks
   // the stall length and the outputs in the DONE cycle and the cycle after
   task automatic applyStimulus(input vec_t v);
      int stallCount = 0;
      int busyCycles = 0;
      bit done = 0;
      MemtoRegM  = v.load;
      MemWriteM  = v.store;
      ALUResultM = v.addr;
      WriteDataM = v.wdata;
      mem_ack    = 1'b0;
      if (v.load || v.store) begin
         reqQueue.push_back('{we: v.store, addr: v.addr, wdata: v.wdata});
      end
      if (v.expValid) begin
         readQueue.push_back(v.rdata);
      end
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         #1;
         if (StallM !== 1'b1) begin
            done = 1;
         end else begin
            stallCount++;
            if (mem_req === 1'b1) begin
               busyCycles++;
               if (busyCycles == v.waits + 1) begin
                  mem_ack   = 1'b1;
                  mem_rdata = v.rdata;
               end else begin
                  mem_rdata = N'($urandom);
               end
            end
            @(negedge clk);
            mem_ack = 1'b0;
         end
      end
      checkOutput("advance_reached", 32'(done), 32'd1);
      checkOutput("stall_cycles", stallCount, v.expStall);
      checkOutput("read_valid_done", ReadValidM, v.expValid);
      if (v.expValid) begin
         lastRead = v.rdata;
      end
      checkOutput("read_data_done", ReadDataM, lastRead);
      checkOutput("req_clear_done", mem_req, 32'd0);
      @(negedge clk);
      MemtoRegM  = 1'b0;
      MemWriteM  = 1'b0;
      ALUResultM = '0;
      WriteDataM = '0;
      #1;
      checkOutput("read_valid_idle", ReadValidM, 32'd0);
      checkOutput("stall_idle", StallM, 32'd0);
   endtask

   // Scoreboard monitor: each new request and each new read result is matched
   // against what the stimulus queued; open requests must stay stable
   initial begin
      logic prevReq = 1'b0;
      logic prevValid = 1'b0;
      req_t held = '{we: 1'b0, addr: '0, wdata: '0};
      forever begin
         @(posedge clk);
         #1;
         if (mem_req && !prevReq) begin
            checkOutput("req_expected", 32'(reqQueue.size() > 0), 32'd1);
            if (reqQueue.size() > 0) begin
               held = reqQueue.pop_front();
               checkOutput("req_we", mem_we, held.we);
               checkOutput("req_addr", mem_addr, held.addr);
               checkOutput("req_wdata", mem_wdata, held.wdata);
            end
         end else if (mem_req && prevReq) begin
            checkOutput("req_addr_stable", mem_addr, held.addr);
            checkOutput("req_wdata_stable", mem_wdata, held.wdata);
            checkOutput("req_we_stable", mem_we, held.we);
         end
         if (ReadValidM && !prevValid) begin
            checkOutput("read_expected", 32'(readQueue.size() > 0), 32'd1);
            if (readQueue.size() > 0) begin
               checkOutput("read_data", ReadDataM, readQueue.pop_front());
            end
         end
         prevReq   = mem_req;
         prevValid = ReadValidM;
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{load: 1'b1, store: 1'b0, addr: 24'h000040, wdata: 24'h000000, rdata: 24'hABCDEF, waits: 0, expStall: 2, expValid: 1'b1};
      vecs[1] = '{load: 1'b0, store: 1'b1, addr: 24'h000100, wdata: 24'h123456, rdata: 24'h000000, waits: 3, expStall: 5, expValid: 1'b0};
      vecs[2] = '{load: 1'b1, store: 1'b1, addr: 24'h000200, wdata: 24'h0F0F0F, rdata: 24'h999999, waits: 1, expStall: 3, expValid: 1'b0};
      vecs[3] = '{load: 1'b0, store: 1'b0, addr: 24'h000333, wdata: 24'h444444, rdata: 24'h000000, waits: 0, expStall: 0, expValid: 1'b0};
      vecs[4] = '{load: 1'b1, store: 1'b0, addr: 24'hFFFFFF, wdata: 24'h000000, rdata: 24'h5A5A5A, waits: 2, expStall: 4, expValid: 1'b1};

      lastRead   = '0;
      rst        = 1'b1;
      MemtoRegM  = 1'b0;
      MemWriteM  = 1'b0;
      ALUResultM = '0;
      WriteDataM = '0;
      mem_ack    = 1'b0;
      mem_rdata  = '0;

      #2;
      checkOutput("reset_mem_req", mem_req, 32'd0);
      checkOutput("reset_mem_addr", mem_addr, 32'd0);
      checkOutput("reset_read_data", ReadDataM, 32'd0);
      checkOutput("reset_read_valid", ReadValidM, 32'd0);
      checkOutput("reset_mem_err", MemErrM, 32'd0);
      checkOutput("reset_stall", StallM, 32'd0);

      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;

      $display("[TB] table-driven accesses (load, store back-to-back, load+store, nop, load)");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i]);
      end

      $display("[TB] reset during a busy load, then acks while idle");
      MemtoRegM  = 1'b1;
      ALUResultM = 24'h000300;
      reqQueue.push_back('{we: 1'b0, addr: 24'h000300, wdata: 24'h000000});
      @(negedge clk);
      #1;
      checkOutput("req_before_reset", mem_req, 32'd1);
      checkOutput("stall_busy", StallM, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("reset_req_drop", mem_req, 32'd0);
      checkOutput("reset_we_clear", mem_we, 32'd0);
      checkOutput("reset_addr_clear", mem_addr, 32'd0);
      checkOutput("reset_rdata_clear", ReadDataM, 32'd0);
      checkOutput("reset_valid_clear", ReadValidM, 32'd0);
      lastRead   = '0;
      MemtoRegM  = 1'b0;
      ALUResultM = '0;
      mem_ack    = 1'b1;
      mem_rdata  = 24'h777777;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      checkOutput("ack_idle_req", mem_req, 32'd0);
      checkOutput("ack_idle_valid", ReadValidM, 32'd0);
      checkOutput("ack_idle_rdata", ReadDataM, 32'd0);
      checkOutput("ack_idle_stall", StallM, 32'd0);
      mem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
      $display("[TB] timeout on a load with no ack");
      applyStimulus('{load: 1'b1, store: 1'b0, addr: 24'h000480, wdata: 24'h000000, rdata: 24'h3C3C3C, waits: 0, expStall: 2, expValid: 1'b1});
      checkOutput("no_err_before_timeout", MemErrM, 32'd0);
      applyStimulus('{load: 1'b1, store: 1'b0, addr: 24'h000500, wdata: 24'h000000, rdata: 24'h000000, waits: -1, expStall: TB_TIMEOUT + 1, expValid: 1'b1});
      checkOutput("err_after_timeout", MemErrM, 32'd1);
      applyStimulus('{load: 1'b0, store: 1'b1, addr: 24'h000600, wdata: 24'h00AA55, rdata: 24'h000000, waits: 1, expStall: 3, expValid: 1'b0});
      checkOutput("err_sticky", MemErrM, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("err_cleared_by_reset", MemErrM, 32'd0);
      lastRead = '0;
      @(negedge clk);
      rst = 1'b0;
      #1;
`endif

      @(negedge clk);
      @(negedge clk);
      checkOutput("req_queue_drained", reqQueue.size(), 32'd0);
      checkOutput("read_queue_drained", readQueue.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/mem_stage_access_ctrl.md
Name: mem_stage_access_ctrl

Overview:
- Memory-stage consumer of the EX/MEM pipeline register outputs (MemtoRegM, MemWriteM, ALUResultM, WriteDataM) in the 24-bit pipelined core.
- Turns each load/store into a req/ack transaction on a variable-latency data-memory port.
- Stalls the pipeline until the transaction completes.
- Presents load data to the MEM/WB register.

Parameters:
- N, 24, datapath and address width.
- TIMEOUT, 255, BUSY cycles before abort (used only with MEM_TIMEOUT_EN).

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-high reset
- MemtoRegM  input  1  load in M stage
- MemWriteM  input  1  store in M stage
- ALUResultM  input  N  effective address
- WriteDataM  input  N  store data
- StallM  output  1  combinational; freezes F/D/E/M registers
- ReadDataM  output  N  registered load data to MEM/WB
- ReadValidM  output  1  registered; ReadDataM valid this cycle
- MemErrM  output  1  sticky timeout error (tied 0 without macro)
- mem_req  output  1  registered request
- mem_we  output  1  registered write enable
- mem_addr  output  N  registered address
- mem_wdata  output  N  registered write data
- mem_ack  input  1  memory completion, one-cycle pulse
- mem_rdata  input  N  read data, valid with mem_ack

Behaviour:
- Reset values (asynchronous): state=IDLE; mem_req, mem_we, ReadValidM, MemErrM = 0; mem_addr, mem_wdata, ReadDataM = 0. StallM follows combinationally.
- Reset mid-transaction: mem_req drops immediately. Any later mem_ack is ignored because state is IDLE and mem_req is 0.
- access = MemtoRegM | MemWriteM. If both bits are set, the access is a write and no read data is captured.
- StallM = access & (state != DONE).
- IDLE:
  - If access is high, go to BUSY on the next edge.
  - On that edge, register mem_req=1, mem_we=MemWriteM, mem_addr=ALUResultM, mem_wdata=WriteDataM.
  - Otherwise remain in IDLE with mem_req=0.
- BUSY:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - mem_ack is sampled only in BUSY; an ack in any other state is ignored.
  - On an edge with mem_ack=1, clear mem_req and go to DONE.
  - On that same edge, if the access was a read: ReadDataM<=mem_rdata, ReadValidM<=1.
- DONE:
  - StallM=0 for exactly one cycle, so the pipeline advances.
  - On the next edge: ReadValidM<=0, return to IDLE.
  - ReadDataM holds its value until the next read completes.
- Latency: an ack in the first BUSY cycle gives 3 cycles from access to advance (IDLE, BUSY, DONE). Each extra wait cycle adds one.
- Back-to-back accesses: IDLE sees the next access one cycle after DONE. No transaction is issued twice, because DONE always returns to IDLE.
- Writes never assert ReadValidM.
- A non-memory instruction in M causes no stall and no request.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count reaches TIMEOUT-1 with no ack: go to DONE, clear mem_req, set ReadDataM=0, ReadValidM=1 for reads, and set MemErrM=1.
  - MemErrM stays set until rst.
  - An ack arriving on the timeout cycle wins: normal completion, no error.
- Undefined:
  - No counter; BUSY waits indefinitely.
  - MemErrM is tied 0.

Decomposition:
- Package mem_stage_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;
  - localparam default TIMEOUT.
- One natural sub-module, mem_timeout_counter (clear, enable, terminal-count output), instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- Load, zero wait: MemtoRegM=1, ALUResultM=0x000040, mem_ack in first BUSY cycle with mem_rdata=0xABCDEF -> mem_addr=0x000040, StallM high 2 cycles, ReadDataM=0xABCDEF with ReadValidM=1 in DONE.
- Store, 3 wait states: MemWriteM=1, WriteDataM=0x123456, ack on 4th BUSY cycle -> mem_we=1, mem_wdata=0x123456 stable throughout, StallM high 5 cycles, ReadValidM stays 0.
- Back-to-back load then store -> exactly two mem_req transactions, addresses in order, no duplicate request.
- Spurious mem_ack while IDLE and an ack after rst asserted mid-BUSY -> ignored; mem_req=0 at once; all outputs at reset values.
- Both MemtoRegM and MemWriteM=1 -> write issued (mem_we=1), ReadValidM stays 0.
- MEM_TIMEOUT_EN, TIMEOUT=8, no ack on a load -> DONE after 8 BUSY cycles, ReadDataM=0, MemErrM=1 held until rst.
